// File: rtl/integral_image_engine.sv
// Streaming integral-image generator.
// Consumes raster-order pixels and emits one buffer write per accepted pixel,
// carrying ii(x,y) = sum of p(i,j) for i<=x, j<=y (modulo 2^SUM_W).
// A one-line buffer holds the previous row's integral values. A running row
// accumulator provides the horizontal prefix sum.
// Capture modes (continuous / single-shot / freeze) are decided on frame_start.
module integral_image_engine #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int PIX_W  = 4,
    parameter int SUM_W  = 20,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic [1:0]        mode,
    input  logic              arm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [SUM_W-1:0]  wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              overflow
);

    // Counter widths. y needs one extra code so that it can hold IMG_H,
    // which marks a completed frame.
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = $clog2(IMG_H + 1);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    localparam logic [1:0] MODE_CONT   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;

    // Frame position and accumulation state
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
    logic [SUM_W-1:0]  row_sum;
    logic              in_frame;   // a started frame still expects pixels
    logic              capture;    // current frame is written to the buffer
    logic              armed;      // single-shot request pending

    // Previous row of integral values, indexed by x
    logic [SUM_W-1:0]  linebuf [IMG_W];

    // Per-cycle view: frame_start forces the coordinates of a coincident
    // pixel to (0,0) of the new frame.
    logic              decision;
    logic              cap_now;
    logic              accept;
    logic              last_pix;
    logic              in_frame_next;
    logic [XW-1:0]     cur_x;
    logic [YW-1:0]     cur_y;
    logic [ADDR_W-1:0] cur_addr;
    logic [SUM_W-1:0]  row_new;
    logic [SUM_W-1:0]  above;
    logic [SUM_W-1:0]  ii;

    // Capture decision, effective coordinates and integral arithmetic
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        decision = 1'b0;
        case (mode)
            MODE_CONT:   decision = 1'b1;
            MODE_SINGLE: decision = armed | arm;
            default:     decision = 1'b0;
        endcase

        cur_x    = frame_start ? '0 : x;
        cur_y    = frame_start ? '0 : y;
        cur_addr = frame_start ? '0 : addr;
        cap_now  = frame_start ? decision : capture;

        accept   = pix_valid & (frame_start | in_frame);
        last_pix = (cur_x == X_LAST) && (cur_y == Y_LAST);

        // Pixel is zero-extended; all adds wrap modulo 2^SUM_W.
        row_new  = ((cur_x == '0) ? '0 : row_sum) + SUM_W'(pix_data);
        above    = (cur_y == '0) ? '0 : linebuf[cur_x];
        ii       = row_new + above;

        if (accept) begin
            in_frame_next = ~last_pix;
        end else begin
            in_frame_next = frame_start | in_frame;
        end
    end

    // Line buffer write: one write per accepted pixel at the read index
    // NOTE: the line buffer has no reset; the y==0 select guarantees an entry
    // is written in the first row before it is ever read, and leaving it
    // unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf[cur_x] <= ii;
        end
    end

    // Frame counters, accumulator, mode flags and registered outputs
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            row_sum    <= '0;
            in_frame   <= 1'b0;
            capture    <= 1'b0;
            armed      <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                row_sum <= row_new;
                addr    <= cur_addr + ADDR_W'(1);
                if (cur_x == X_LAST) begin
                    x <= '0;
                    y <= cur_y + YW'(1);
                end else begin
                    x <= cur_x + XW'(1);
                    y <= cur_y;
                end
                wr_addr <= cur_addr;
                wr_data <= ii;
            end else if (frame_start) begin
                x       <= '0;
                y       <= '0;
                addr    <= '0;
                row_sum <= '0;
            end

            in_frame   <= in_frame_next;
            capture    <= cap_now;
            wr_en      <= accept & cap_now;
            frame_done <= accept & cap_now & last_pix;
            busy       <= cap_now & in_frame_next;

            // Pixels outside a frame are dropped and flagged until restart.
            if (frame_start) begin
                overflow <= 1'b0;
            end else if (pix_valid && !in_frame) begin
                overflow <= 1'b1;
            end

            // A single-shot frame_start consumes the arm, including a
            // coincident arm pulse.
            if (frame_start && (mode == MODE_SINGLE)) begin
                armed <= 1'b0;
            end else if (arm) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_integral_image_engine.sv
// Self-checking bench for integral_image_engine on a 4x3 image with 6-bit sums.
// A reference model computes each expected ii(x,y) as a direct rectangle sum
// and queues the expected writes; a negedge monitor pops and compares them.
module tb_integral_image_engine;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int PIX_W  = 4;
    localparam int SUM_W  = 6;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              frame_start;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic [1:0]        mode;
    logic              arm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [SUM_W-1:0]  wr_data;
    logic              frame_done;
    logic              busy;
    logic              overflow;

    integral_image_engine #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (PIX_W),
        .SUM_W (SUM_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .mode       (mode),
        .arm        (arm),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SUM_W-1:0]  data;
        logic              done;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    int done_count = 0;
    logic [SUM_W-1:0] seen [16];

    // Reference model state
    int mx, my;
    bit m_in, m_cap, m_armed, m_ovf;
    int pm [IMG_H][IMG_W];

    function automatic int rect_sum(input int xx, input int yy);
        int s = 0;
        for (int j = 0; j <= yy; j++)
            for (int i = 0; i <= xx; i++)
                s += pm[j][i];
        return s % (1 << SUM_W);
    endfunction

    // Scoreboard consumer: every write is compared against the queue head
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_count++;
            tests++;
            seen[wr_addr] = wr_data;
            if (frame_done === 1'b1) done_count++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_write: got addr %0d data %0d done %0b, none expected",
                         wr_addr, wr_data, frame_done);
            end else begin
                mon_e = q.pop_front();
                if ({wr_addr, wr_data, frame_done} !== {mon_e.addr, mon_e.data, mon_e.done}) begin
                    fails++;
                    $display("FAIL sb_write: got addr %0d data %0d done %0b, want addr %0d data %0d done %0b",
                             wr_addr, wr_data, frame_done, mon_e.addr, mon_e.data, mon_e.done);
                end
            end
        end else if (frame_done !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL sb_done_without_write: frame_done %0b with wr_en %0b", frame_done, wr_en);
        end
    end

    // One clock of stimulus; the model predicts the resulting write, if any
    task automatic cycle(input bit fs, input bit pv, input int p, input bit a);
        exp_t ne;
        if (a) m_armed = 1'b1;
        if (fs) begin
            mx = 0; my = 0; m_in = 1'b1; m_ovf = 1'b0;
            case (mode)
                2'b00: m_cap = 1'b1;
                2'b01: begin m_cap = m_armed; m_armed = 1'b0; end
                default: m_cap = 1'b0;
            endcase
        end
        if (pv) begin
            if (m_in) begin
                pm[my][mx] = p;
                if (m_cap) begin
                    ne.addr = ADDR_W'(my * IMG_W + mx);
                    ne.data = SUM_W'(rect_sum(mx, my));
                    ne.done = (mx == IMG_W - 1) && (my == IMG_H - 1);
                    q.push_back(ne);
                end
                if (mx == IMG_W - 1) begin
                    mx = 0; my++;
                    if (my == IMG_H) m_in = 1'b0;
                end else begin
                    mx++;
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
        frame_start = fs; pix_valid = pv; pix_data = PIX_W'(p); arm = a;
        @(posedge clk); #1;
        frame_start = 1'b0; pix_valid = 1'b0; arm = 1'b0;
    endtask

    task automatic model_reset();
        m_in = 1'b0; m_cap = 1'b0; m_armed = 1'b0; m_ovf = 1'b0;
        mx = 0; my = 0;
        q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; frame_start = 0; pix_valid = 0; pix_data = 0; mode = 2'b00; arm = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #10;
        tests++;
        if ({wr_en, wr_addr, wr_data, frame_done, busy, overflow} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {wr_en, wr_addr, wr_data, frame_done, busy, overflow});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_continuous();
        mode = 2'b00; wr_count = 0; done_count = 0;
        cycle(1, 0, 0, 0);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL cont_busy_rise: got %0b want 1", busy); end
        for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0);
        tests++;
        if ({wr_en, frame_done, wr_addr, wr_data} !== {1'b1, 1'b1, 4'd11, 6'd12}) begin
            fails++;
            $display("FAIL cont_last_write: got en %0b done %0b addr %0d data %0d, want 1 1 11 12",
                     wr_en, frame_done, wr_addr, wr_data);
        end
        cycle(0, 0, 0, 0);
        tests++;
        if ({busy, frame_done} !== 2'b00) begin
            fails++; $display("FAIL cont_busy_fall: got busy %0b done %0b want 0 0", busy, frame_done);
        end
        tests++;
        if (wr_count !== 12 || done_count !== 1 || q.size() !== 0) begin
            fails++;
            $display("FAIL cont_counts: got writes %0d dones %0d pending %0d, want 12 1 0",
                     wr_count, done_count, q.size());
        end
    endtask

    task automatic test_wrap();
        mode = 2'b00;
        for (int i = 0; i < 16; i++) seen[i] = '0;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 1, 15, 0);
        cycle(0, 0, 0, 0);
        tests++;
        if (seen[3] !== 6'd60 || seen[4] !== 6'd30 || seen[11] !== 6'd52) begin
            fails++;
            $display("FAIL wrap_values: got ii(3,0) %0d ii(0,1) %0d ii(3,2) %0d, want 60 30 52",
                     seen[3], seen[4], seen[11]);
        end
    endtask

    task automatic test_single_shot();
        mode = 2'b01; wr_count = 0;
        for (int f = 0; f < 2; f++) begin
            cycle(1, 0, 0, 0);
            for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0);
        end
        tests++;
        if (wr_count !== 0 || busy !== 1'b0) begin
            fails++; $display("FAIL single_unarmed: got writes %0d busy %0b, want 0 0", wr_count, busy);
        end
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %0b want 1", busy); end
        for (int i = 0; i < 12; i++) cycle(0, 1, i, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0);
        cycle(0, 0, 0, 0);
        tests++;
        if (wr_count !== 12) begin fails++; $display("FAIL single_once: got writes %0d want 12", wr_count); end
        // Arm coincident with frame_start is consumed by that frame
        wr_count = 0;
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 12; i++) cycle(0, 1, 2, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 1, 2, 0);
        cycle(0, 0, 0, 0);
        tests++;
        if (wr_count !== 12) begin fails++; $display("FAIL single_arm_with_start: got writes %0d want 12", wr_count); end
    endtask

    task automatic test_abort();
        mode = 2'b00; wr_count = 0; done_count = 0;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 2, 0);
        tests++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd0, 6'd2}) begin
            fails++;
            $display("FAIL abort_restart: got en %0b addr %0d data %0d, want 1 0 2", wr_en, wr_addr, wr_data);
        end
        for (int i = 0; i < 11; i++) cycle(0, 1, 2, 0);
        cycle(0, 0, 0, 0);
        tests++;
        if (done_count !== 1 || seen[11] !== 6'd24 || wr_count !== 18) begin
            fails++;
            $display("FAIL abort_counts: got dones %0d final %0d writes %0d, want 1 24 18",
                     done_count, seen[11], wr_count);
        end
    endtask

    task automatic test_overflow();
        mode = 2'b00; wr_count = 0;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 1, 3, 0);
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %0b want 0", overflow); end
        cycle(0, 1, 3, 0);
        tests++;
        if ({overflow, wr_en} !== {m_ovf, 1'b0}) begin
            fails++; $display("FAIL ovf_13th: got ovf %0b wr_en %0b, want 1 0", overflow, wr_en);
        end
        cycle(0, 1, 3, 0);
        cycle(0, 0, 0, 0);
        tests++;
        if (overflow !== 1'b1 || wr_count !== 12) begin
            fails++; $display("FAIL ovf_hold: got ovf %0b writes %0d, want 1 12", overflow, wr_count);
        end
        cycle(1, 0, 0, 0);
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        mode = 2'b00; wr_count = 0;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, $urandom_range(0, 15), 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({wr_en, wr_addr, wr_data, frame_done, busy, overflow} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %b, want all zero",
                     {wr_en, wr_addr, wr_data, frame_done, busy, overflow});
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) cycle(0, 1, 5, 0);
        cycle(0, 0, 0, 0);
        tests++;
        if (overflow !== 1'b1 || wr_count !== 5) begin
            fails++; $display("FAIL reset_mid_drop: got ovf %0b writes %0d, want 1 5", overflow, wr_count);
        end
    endtask

    task automatic test_back_to_back();
        mode = 2'b00; wr_count = 0; done_count = 0;
        for (int f = 0; f < 2; f++) begin
            cycle(1, 1, $urandom_range(0, 15), 0);
            for (int i = 1; i < 12; i++) cycle(0, 1, $urandom_range(0, 15), 0);
        end
        cycle(0, 0, 0, 0);
        tests++;
        if (wr_count !== 24 || done_count !== 2 || q.size() !== 0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL b2b_counts: got writes %0d dones %0d pending %0d ovf %0b, want 24 2 0 0",
                     wr_count, done_count, q.size(), overflow);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_wrap();
        test_single_shot();
        test_abort();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/integral_image_engine.md
Name: integral_image_engine

Overview:
- Streaming integral-image generator, parametrised in image size, pixel width and sum width; successor to the fixed 160x120 capture path.
- Sits between the pixel source (camera capture or grayscale converter) and the dual-port integral image buffer.
- Computes ii(x,y) = sum of p(i,j) for all i<=x, j<=y, and emits one buffer write per accepted pixel.
- Adds capture modes: continuous, single-shot (armed) and freeze, plus frame-done, busy and overflow status.

Parameters:
- IMG_W, 160, pixels per line
- IMG_H, 120, lines per frame
- PIX_W, 4, input pixel width (unsigned)
- SUM_W, 20, integral value width; sums wrap modulo 2^SUM_W
- ADDR_W, 15, buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- clk  in  1  single clock for all logic (pixel clock domain)
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse marking a new frame (from vsync edge)
- pix_valid  in  1  pix_data valid this cycle
- pix_data  in  PIX_W  pixel intensity, raster order
- mode  in  2  00 continuous, 01 single-shot, 10/11 freeze
- arm  in  1  one-cycle pulse; arms single-shot capture
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  y*IMG_W + x
- wr_data  out  SUM_W  ii(x,y)
- frame_done  out  1  one-cycle pulse after the last write of a captured frame
- busy  out  1  high while a captured frame is in progress
- overflow  out  1  sticky: pixel received beyond IMG_W*IMG_H

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; x, y, row accumulator, armed flag, capture flag and overflow cleared. Line buffer contents are don't-care; the first-row flag guarantees they are never read before being written.
- Arithmetic per accepted pixel:
  - row_sum = (x==0 ? 0 : row_sum) + p
  - ii = row_sum_new + (y==0 ? 0 : linebuf[x])
  - linebuf[x] <= ii
  - All adds are SUM_W wide, wrap modulo 2^SUM_W, no saturation; pixel is zero-extended.
- Line buffer: IMG_W x SUM_W, one read and one write per pixel at the same index x. Implementations may use registers or inferred RAM.
- Latency: wr_en, wr_addr and wr_data are registered and valid exactly 1 cycle after the accepting pix_valid cycle. Back-to-back pixels on every cycle are required at full rate, with no stalls.
- Counters: x increments per accepted pixel. At x==IMG_W-1, x wraps to 0 and y increments. After pixel (IMG_W-1, IMG_H-1), the frame is complete.
- Capture decision, sampled only on frame_start:
  - continuous: capture = 1
  - single-shot: capture = armed; armed is cleared on that frame_start
  - freeze: capture = 0
  - mode changes mid-frame take effect at the next frame_start.
- arm: sets armed and holds it until consumed. An arm arriving in the same cycle as frame_start is consumed immediately.
- frame_start: resets x, y and row_sum, and clears overflow. If a pix_valid occurs in the same cycle, that pixel is processed as (0,0) of the new frame.
- Non-captured frames: counters still run, but wr_en stays 0.
- Completion: frame_done pulses for one cycle, in the same cycle as the final wr_en. busy rises the cycle after a capturing frame_start and falls with frame_done.
- Early frame_start before completion: busy is re-evaluated per the new capture decision and frame_done does not pulse for the aborted frame; buffer contents are partial.
- Overflow: pix_valid after frame completion (y==IMG_H) is dropped with no write, and overflow is set until the next frame_start or reset. pix_valid before any frame_start since reset is likewise dropped and counted as overflow.
- Reset mid-frame: aborts immediately, with no frame_done pulse.

Test Plan:
1. IMG_W=4, IMG_H=3, mode=00, frame_start then 12 pixels all =1 -> 12 writes, addr 0..11, data (x+1)(y+1); last write addr 11 data 12 with frame_done high; busy low the following cycle.
2. Same size, PIX_W=4, SUM_W=6, all pixels 15 -> last wr_data = 180 mod 64 = 52; ii(3,0) = 60; ii(0,1) = 30.
3. mode=01 without arm: two frames produce no wr_en. Then arm pulse, then frame -> 12 writes. The next frame produces none.
4. mode=00, frame_start after 6 pixels, then 12 pixels of value 2 -> restarts at addr 0 with data 2, no frame_done for the aborted frame, final data 24.
5. 14 pixels after frame_start -> 12 writes, overflow=1 from the 13th pixel, cleared by the next frame_start.
6. rst_n low mid-frame at pixel 5 -> all outputs 0 asynchronously. After release, pixels without frame_start are dropped and overflow=1; a subsequent frame computes correctly.
